// File: rtl/ctrl_pipe.sv
// Control path of a 5-stage RV32I(M) pipeline: ID decode, EX/MEM/WB control
// registers, load-use and multi-cycle MUL interlocks, branch flush.
module ctrl_pipe #(
  parameter int EN_MUL  = 1,
  parameter int MUL_LAT = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] inst,
  input  logic        id_valid,
  input  logic        branch_taken,
  input  logic        ext_stall,
  output logic        ex_branch,
  output logic        ex_alusrc,
  output logic        ex_mem_rena,
  output logic        ex_mem_wena,
  output logic        ex_reg_wena,
  output logic        ex_mem2reg,
  output logic [1:0]  ex_aluop,
  output logic [1:0]  ex_jump,
  output logic [4:0]  ex_rd,
  output logic        mem_mem_rena,
  output logic        mem_mem_wena,
  output logic        mem_reg_wena,
  output logic        mem_mem2reg,
  output logic [4:0]  mem_rd,
  output logic        wb_reg_wena,
  output logic        wb_mem2reg,
  output logic [4:0]  wb_rd,
  output logic        stall_if,
  output logic        flush_id,
  output logic        illegal
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_BR  = 2'b01;
  localparam logic [1:0] ALU_FN  = 2'b10;
  localparam logic [1:0] ALU_MUL = 2'b11;

  localparam logic [3:0] MUL_LOAD = 4'(MUL_LAT - 1);

  typedef struct packed {
    logic       branch;
    logic       alusrc;
    logic       mem_rena;
    logic       mem_wena;
    logic       reg_wena;
    logic       mem2reg;
    logic [1:0] aluop;
    logic [1:0] jump;
    logic [4:0] rd;
  } ex_ctrl_t;

  typedef struct packed {
    logic       mem_rena;
    logic       mem_wena;
    logic       reg_wena;
    logic       mem2reg;
    logic [4:0] rd;
  } mem_ctrl_t;

  typedef struct packed {
    logic       reg_wena;
    logic       mem2reg;
    logic [4:0] rd;
  } wb_ctrl_t;

  ex_ctrl_t  id_c, ex_q;
  mem_ctrl_t mem_q, ex_to_mem;
  wb_ctrl_t  wb_q, mem_to_wb;
  logic [3:0] mul_cnt;
  logic       bad_op, load_use, mul_busy;
  logic       unused_funct3;

  assign unused_funct3 = ^inst[14:12];

  // NOTE: every field gets a default before the case so no path leaves a latch.
  always_comb begin
    id_c   = '0;
    bad_op = 1'b0;
    unique case (inst[6:0])
      OP_R: begin
        id_c.reg_wena = 1'b1;
        id_c.aluop    = (EN_MUL != 0 && inst[31:25] == 7'b0000001) ? ALU_MUL : ALU_FN;
      end
      OP_I: begin
        id_c.reg_wena = 1'b1;
        id_c.alusrc   = 1'b1;
        id_c.aluop    = ALU_FN;
      end
      OP_LOAD: begin
        id_c.reg_wena = 1'b1;
        id_c.mem2reg  = 1'b1;
        id_c.mem_rena = 1'b1;
        id_c.alusrc   = 1'b1;
      end
      OP_STORE: begin
        id_c.mem_wena = 1'b1;
        id_c.alusrc   = 1'b1;
      end
      OP_BRANCH: begin
        id_c.branch = 1'b1;
        id_c.aluop  = ALU_BR;
      end
      OP_JAL: begin
        id_c.reg_wena = 1'b1;
        id_c.alusrc   = 1'b1;
        id_c.jump     = 2'b01;
      end
      OP_JALR: begin
        id_c.reg_wena = 1'b1;
        id_c.alusrc   = 1'b1;
        id_c.jump     = 2'b10;
      end
      OP_LUI, OP_AUIPC: begin
        id_c.reg_wena = 1'b1;
        id_c.alusrc   = 1'b1;
      end
      default: bad_op = 1'b1;
    endcase
    // Writes to x0 are dropped, and rd is only meaningful when a write happens.
    if (id_c.reg_wena && inst[11:7] != 5'd0) id_c.rd = inst[11:7];
    else                                      id_c.reg_wena = 1'b0;
    if (!id_valid) id_c = '0;
  end

  assign illegal  = id_valid && bad_op;
  assign mul_busy = (mul_cnt != 4'd0);
  assign load_use = ex_q.mem_rena && ex_q.rd != 5'd0 && id_valid &&
                    (ex_q.rd == inst[19:15] || ex_q.rd == inst[24:20]);

  assign flush_id = !ext_stall && branch_taken;
  assign stall_if = ext_stall || (!branch_taken && (mul_busy || load_use));

  assign ex_to_mem = '{mem_rena: ex_q.mem_rena, mem_wena: ex_q.mem_wena,
                       reg_wena: ex_q.reg_wena, mem2reg: ex_q.mem2reg, rd: ex_q.rd};
  assign mem_to_wb = '{reg_wena: mem_q.reg_wena, mem2reg: mem_q.mem2reg, rd: mem_q.rd};

  // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
      mul_cnt <= '0;
    end else if (!ext_stall) begin
      wb_q <= mem_to_wb;
      if (mul_busy) mul_cnt <= mul_cnt - 4'd1;
      if (branch_taken) begin
        ex_q  <= '0;
        mem_q <= ex_to_mem;
      end else if (mul_busy) begin
        mem_q <= '0;
      end else if (load_use) begin
        ex_q  <= '0;
        mem_q <= ex_to_mem;
      end else begin
        ex_q  <= id_c;
        mem_q <= ex_to_mem;
        if (id_c.aluop == ALU_MUL) mul_cnt <= MUL_LOAD;
      end
    end
  end

  assign ex_branch   = ex_q.branch;
  assign ex_alusrc   = ex_q.alusrc;
  assign ex_mem_rena = ex_q.mem_rena;
  assign ex_mem_wena = ex_q.mem_wena;
  assign ex_reg_wena = ex_q.reg_wena;
  assign ex_mem2reg  = ex_q.mem2reg;
  assign ex_aluop    = ex_q.aluop;
  assign ex_jump     = ex_q.jump;
  assign ex_rd       = ex_q.rd;

  assign mem_mem_rena = mem_q.mem_rena;
  assign mem_mem_wena = mem_q.mem_wena;
  assign mem_reg_wena = mem_q.reg_wena;
  assign mem_mem2reg  = mem_q.mem2reg;
  assign mem_rd       = mem_q.rd;

  assign wb_reg_wena = wb_q.reg_wena;
  assign wb_mem2reg  = wb_q.mem2reg;
  assign wb_rd       = wb_q.rd;

endmodule
